// File: rtl/port_traffic_gen.sv
// LFSR-driven packet source for one switch input port: programmed packet count, idle gap, launch/drop counters.
// Optional BACKPRESSURE_EN macro: hold the packet while port_full=1 instead of launching into a full FIFO.
module port_traffic_gen #(
  parameter int          PORT_ID   = 0,
  parameter int          NUM_PORTS = 4,
  parameter int          DATA_W    = 8,
  parameter int          CNT_W     = 16,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [CNT_W-1:0]     num_pkts,
  input  logic [3:0]           gap,
  input  logic [1:0]           mode,
  input  logic [NUM_PORTS-1:0] fixed_target,
  input  logic                 port_full,
  output logic                 valid_in,
  output logic [3:0]           source_in,
  output logic [NUM_PORTS-1:0] target_in,
  output logic [DATA_W-1:0]    data_in,
  output logic                 busy,
  output logic                 done,
  output logic [CNT_W-1:0]     sent_cnt,
  output logic [CNT_W-1:0]     drop_cnt
);

  typedef enum logic [1:0] {IDLE, SEND, GAP, FIN} state_t;

  localparam logic [NUM_PORTS-1:0] SELF     = NUM_PORTS'(1) << PORT_ID;
  localparam logic [NUM_PORTS-1:0] FALLBACK = NUM_PORTS'(1) << ((PORT_ID + 1) % NUM_PORTS);
  localparam logic [CNT_W-1:0]     CNT_MAX  = {CNT_W{1'b1}};

  state_t               r_state, w_next;
  logic [15:0]          r_lfsr, w_lfsr_nxt;
  logic [CNT_W-1:0]     r_remain, r_sent, r_drop;
  logic [3:0]           r_gap, r_gcnt;
  logic [1:0]           r_mode, w_mode;
  logic [NUM_PORTS-1:0] r_target, w_raw, w_masked, w_target;
  logic [DATA_W-1:0]    r_data;
  logic                 w_start, w_launch, w_load;

  assign w_start = (r_state == IDLE) && start;
`ifdef BACKPRESSURE_EN
  assign w_launch = (r_state == SEND) && !port_full;
`else
  assign w_launch = (r_state == SEND);
`endif
  assign w_load     = (w_start && num_pkts != '0) || (w_launch && r_remain != '0);
  assign w_lfsr_nxt = {r_lfsr[0] ^ r_lfsr[2] ^ r_lfsr[3] ^ r_lfsr[5], r_lfsr[15:1]};

  // Packet 1 is loaded in the start cycle, before r_mode has been captured.
  assign w_mode = (r_state == IDLE) ? mode : r_mode;

  always_comb begin
    w_raw = r_lfsr[NUM_PORTS-1:0];
    case (w_mode)
      2'b01:   w_raw = fixed_target;
      2'b10:   w_raw = '1;
      default: w_raw = r_lfsr[NUM_PORTS-1:0];
    endcase
  end

  assign w_masked = w_raw & ~SELF;
  assign w_target = (w_masked == '0) ? FALLBACK : w_masked;

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: if (start) w_next = (num_pkts == '0) ? FIN : SEND;
      SEND: if (w_launch) begin
        if (r_remain == '0)   w_next = FIN;
        else if (r_gap != '0) w_next = GAP;
      end
      GAP:     if (r_gcnt == 4'd1) w_next = SEND;
      FIN:     w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_lfsr   <= LFSR_SEED;
      r_remain <= '0;
      r_sent   <= '0;
      r_drop   <= '0;
      r_gap    <= '0;
      r_gcnt   <= '0;
      r_mode   <= '0;
      r_target <= '0;
      r_data   <= '0;
    end else begin
      r_state <= w_next;
      if (w_start) begin
        r_gap    <= gap;
        r_mode   <= mode;
        r_sent   <= '0;
        r_drop   <= '0;
        r_remain <= num_pkts - 1'b1;
      end
      if (w_launch) begin
        if (r_sent != CNT_MAX)  r_sent   <= r_sent + 1'b1;
        if (r_remain != '0)     r_remain <= r_remain - 1'b1;
`ifndef BACKPRESSURE_EN
        if (port_full && r_drop != CNT_MAX) r_drop <= r_drop + 1'b1;
`endif
        r_gcnt <= r_gap;
      end
      if (r_state == GAP) r_gcnt <= r_gcnt - 1'b1;
      if (w_load) begin
        r_target <= w_target;
        r_data   <= r_lfsr[15:16-DATA_W];
        r_lfsr   <= w_lfsr_nxt;
      end
    end
  end

  assign valid_in  = w_launch;
  assign source_in = 4'(PORT_ID);
  assign target_in = r_target;
  assign data_in   = r_data;
  assign busy      = (r_state != IDLE);
  assign done      = (r_state == FIN);
  assign sent_cnt  = r_sent;
  assign drop_cnt  = r_drop;

endmodule

// File: tb/tb_port_traffic_gen.sv
// Scoreboard bench for port_traffic_gen: two instances (PORT_ID 0 and 2), expected packets queued from a reference LFSR.
module tb_port_traffic_gen;
  typedef struct packed { logic [3:0] t; logic [7:0] d; } pkt_t;

  logic        clk = 1'b0;
  logic        rst, start0, start2, port_full;
  logic [15:0] num_pkts;
  logic [3:0]  gap, fixed_target;
  logic [1:0]  mode;

  logic        valid0, busy0, done0, valid2, busy2, done2;
  logic [3:0]  src0, tgt0, src2, tgt2;
  logic [7:0]  dat0, dat2;
  logic [15:0] sent0, drop0, sent2, drop2;

  int errs = 0, checks = 0;
  pkt_t exp_q[$];
  logic [15:0] mlfsr0, mlfsr2;

  logic full_pat [0:63];
  logic rst_pat  [0:63];
  int   n_obs, done_cyc, done_cnt;
  int   obs_cyc [0:63];
  logic [3:0] obs_tgt [0:63];
  logic [7:0] obs_dat [0:63];
  logic obs_full [0:63];
  logic busy_hist [0:63];

  port_traffic_gen #(.PORT_ID(0)) dut0 (
    .clk(clk), .rst(rst), .start(start0), .num_pkts(num_pkts), .gap(gap), .mode(mode),
    .fixed_target(fixed_target), .port_full(port_full), .valid_in(valid0), .source_in(src0),
    .target_in(tgt0), .data_in(dat0), .busy(busy0), .done(done0), .sent_cnt(sent0), .drop_cnt(drop0));

  port_traffic_gen #(.PORT_ID(2)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .num_pkts(num_pkts), .gap(gap), .mode(mode),
    .fixed_target(fixed_target), .port_full(port_full), .valid_in(valid2), .source_in(src2),
    .target_in(tgt2), .data_in(dat2), .busy(busy2), .done(done2), .sent_cnt(sent2), .drop_cnt(drop2));

  always #5 clk = ~clk;

  function automatic logic [15:0] lfsr_nxt(input logic [15:0] s);
    return {s[0] ^ s[2] ^ s[3] ^ s[5], s[15:1]};
  endfunction

  function automatic logic [3:0] tgt_rule(input int pid, input logic [1:0] m, input logic [3:0] fx, input logic [15:0] s);
    logic [3:0] r;
    r = (m == 2'b01) ? fx : (m == 2'b10) ? 4'hF : s[3:0];
    r[pid] = 1'b0;
    if (r == 4'h0) r[(pid + 1) % 4] = 1'b1;
    return r;
  endfunction

  task automatic push_exp(input bit which, input logic [1:0] m, input int n);
    logic [15:0] s;
    s = which ? mlfsr2 : mlfsr0;
    for (int i = 0; i < n; i++) begin
      exp_q.push_back({tgt_rule(which ? 2 : 0, m, fixed_target, s), s[15:8]});
      s = lfsr_nxt(s);
    end
    if (which) mlfsr2 = s; else mlfsr0 = s;
  endtask

  // Cycle c=0 drives start; stops one cycle after done or at cap. Called #1 after a posedge.
  task automatic run(input bit which, input int n, input logic [3:0] g, input logic [1:0] m, input int cap);
    n_obs = 0; done_cyc = -1; done_cnt = 0;
    num_pkts = 16'(n); gap = g; mode = m;
    for (int c = 0; c < cap; c++) begin
      start0 = !which && (c == 0);
      start2 = which && (c == 0);
      port_full = full_pat[c];
      rst = rst_pat[c];
      @(negedge clk);
      busy_hist[c] = which ? busy2 : busy0;
      if ((which ? valid2 : valid0) && n_obs < 64) begin
        obs_cyc[n_obs] = c; obs_full[n_obs] = port_full;
        obs_tgt[n_obs] = which ? tgt2 : tgt0;
        obs_dat[n_obs] = which ? dat2 : dat0;
        n_obs++;
      end
      if (which ? done2 : done0) begin
        if (done_cyc < 0) done_cyc = c;
        done_cnt++;
      end
      @(posedge clk); #1;
      if (done_cyc >= 0 && c > done_cyc) break;
    end
    start0 = 0; start2 = 0; port_full = 0; rst = 0;
    for (int i = 0; i < 64; i++) begin full_pat[i] = 0; rst_pat[i] = 0; end
  endtask

  task automatic test_reset();
    rst = 1; start0 = 0; start2 = 0; port_full = 0; num_pkts = 0; gap = 0; mode = 0; fixed_target = 0;
    repeat (3) @(posedge clk);
    #1 rst = 0;
    mlfsr0 = 16'hACE1; mlfsr2 = 16'hACE1;
    @(negedge clk);
    checks++; if ({valid0, busy0, done0, valid2, busy2, done2} !== 6'b0) begin errs++; $display("FAIL reset_ctrl: got %b expected 000000", {valid0, busy0, done0, valid2, busy2, done2}); end
    checks++; if ({tgt0, dat0, sent0, drop0} !== 44'h0) begin errs++; $display("FAIL reset_data: got %h expected 0", {tgt0, dat0, sent0, drop0}); end
    checks++; if ({src0, src2} !== 8'h02) begin errs++; $display("FAIL reset_src: got %h expected 02", {src0, src2}); end
    @(posedge clk); #1;
  endtask

  task automatic test_broadcast();
    pkt_t e;
    push_exp(1, 2'b10, 5);
    run(1, 5, 4'd0, 2'b10, 12);
    checks++; if (n_obs !== 5) begin errs++; $display("FAIL bcast_count: got %0d expected 5", n_obs); end
    for (int i = 0; i < n_obs; i++) if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++; if ({obs_tgt[i], obs_dat[i]} !== {e.t, e.d}) begin errs++; $display("FAIL bcast_pkt%0d: got %h expected %h", i, {obs_tgt[i], obs_dat[i]}, {e.t, e.d}); end
      checks++; if (obs_tgt[i] !== 4'b1011 || obs_cyc[i] !== i + 1) begin errs++; $display("FAIL bcast_tgt_cyc%0d: got %b@%0d expected 1011@%0d", i, obs_tgt[i], obs_cyc[i], i + 1); end
    end
    checks++; if (done_cyc !== 6 || done_cnt !== 1) begin errs++; $display("FAIL bcast_done: got cyc %0d cnt %0d expected 6/1", done_cyc, done_cnt); end
    checks++; if (sent2 !== 16'd5 || drop2 !== 16'd0) begin errs++; $display("FAIL bcast_cnt: got %0d/%0d expected 5/0", sent2, drop2); end
    exp_q.delete();
  endtask

  task automatic test_midrun_reset();
    pkt_t e;
    push_exp(0, 2'b00, 3);
    rst_pat[3] = 1;
    run(0, 10, 4'd0, 2'b00, 8);
    mlfsr0 = 16'hACE1; mlfsr2 = 16'hACE1;
    checks++; if (n_obs !== 3) begin errs++; $display("FAIL rstmid_count: got %0d expected 3", n_obs); end
    for (int i = 0; i < n_obs; i++) if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++; if ({obs_tgt[i], obs_dat[i]} !== {e.t, e.d}) begin errs++; $display("FAIL rstmid_pkt%0d: got %h expected %h", i, {obs_tgt[i], obs_dat[i]}, {e.t, e.d}); end
    end
    checks++; if (busy_hist[4] !== 1'b0 || done_cnt !== 0) begin errs++; $display("FAIL rstmid_idle: got busy %b done %0d expected 0/0", busy_hist[4], done_cnt); end
    checks++; if (sent0 !== 16'd0) begin errs++; $display("FAIL rstmid_sent: got %0d expected 0", sent0); end
    exp_q.delete();
    push_exp(0, 2'b00, 3);
    run(0, 3, 4'd0, 2'b00, 10);
    checks++; if (n_obs !== 3 || done_cyc !== 4) begin errs++; $display("FAIL rerun_shape: got %0d@%0d expected 3@4", n_obs, done_cyc); end
    for (int i = 0; i < n_obs; i++) if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++; if ({obs_tgt[i], obs_dat[i]} !== {e.t, e.d}) begin errs++; $display("FAIL rerun_pkt%0d: got %h expected %h", i, {obs_tgt[i], obs_dat[i]}, {e.t, e.d}); end
    end
    exp_q.delete();
  endtask

  task automatic test_fixed_fallback();
    pkt_t e;
    fixed_target = 4'b0001;
    push_exp(0, 2'b01, 1);
    run(0, 1, 4'd0, 2'b01, 8);
    checks++; if (n_obs !== 1 || done_cyc !== 2) begin errs++; $display("FAIL fixed_shape: got %0d@%0d expected 1@2", n_obs, done_cyc); end
    if (n_obs > 0) begin
      e = exp_q.pop_front();
      checks++; if (obs_tgt[0] !== 4'b0010 || obs_dat[0] !== e.d) begin errs++; $display("FAIL fixed_pkt: got %b/%h expected 0010/%h", obs_tgt[0], obs_dat[0], e.d); end
    end
    exp_q.delete();
    fixed_target = 4'b0000;
  endtask

  task automatic test_gap();
    pkt_t e;
    push_exp(0, 2'b00, 4);
    run(0, 4, 4'd3, 2'b00, 24);
    checks++; if (n_obs !== 4 || done_cyc !== 14) begin errs++; $display("FAIL gap_shape: got %0d@%0d expected 4@14", n_obs, done_cyc); end
    for (int i = 0; i < n_obs; i++) if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++; if ({obs_tgt[i], obs_dat[i]} !== {e.t, e.d} || obs_cyc[i] !== 1 + 4 * i) begin errs++; $display("FAIL gap_pkt%0d: got %h@%0d expected %h@%0d", i, {obs_tgt[i], obs_dat[i]}, obs_cyc[i], {e.t, e.d}, 1 + 4 * i); end
    end
    checks++; if (sent0 !== 16'd4 || busy_hist[15] !== 1'b0) begin errs++; $display("FAIL gap_end: got sent %0d busy %b expected 4/0", sent0, busy_hist[15]); end
    exp_q.delete();
  endtask

  task automatic test_zero_pkts();
    run(0, 0, 4'd0, 2'b00, 6);
    checks++; if (n_obs !== 0 || done_cyc !== 1 || done_cnt !== 1) begin errs++; $display("FAIL zero_shape: got %0d launches done@%0d x%0d expected 0/1/1", n_obs, done_cyc, done_cnt); end
    checks++; if (sent0 !== 16'd0 || drop0 !== 16'd0) begin errs++; $display("FAIL zero_cnt: got %0d/%0d expected 0/0", sent0, drop0); end
  endtask

  task automatic test_reserved_mode();
    pkt_t e;
    push_exp(1, 2'b00, 3);
    run(1, 3, 4'd1, 2'b11, 12);
    checks++; if (n_obs !== 3 || done_cyc !== 6) begin errs++; $display("FAIL rsv_shape: got %0d@%0d expected 3@6", n_obs, done_cyc); end
    for (int i = 0; i < n_obs; i++) if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++; if ({obs_tgt[i], obs_dat[i]} !== {e.t, e.d} || obs_cyc[i] !== 1 + 2 * i) begin errs++; $display("FAIL rsv_pkt%0d: got %h@%0d expected %h@%0d", i, {obs_tgt[i], obs_dat[i]}, obs_cyc[i], {e.t, e.d}, 1 + 2 * i); end
    end
    exp_q.delete();
  endtask

  task automatic test_port_full();
    pkt_t e;
    int nf;
    push_exp(0, 2'b00, 10);
    for (int i = 3; i <= 8; i++) full_pat[i] = 1;
    run(0, 10, 4'd0, 2'b00, 30);
    nf = 0;
    for (int i = 0; i < n_obs; i++) if (obs_full[i]) nf++;
    checks++; if (n_obs !== 10 || sent0 !== 16'd10) begin errs++; $display("FAIL full_sent: got %0d/%0d expected 10/10", n_obs, sent0); end
    for (int i = 0; i < n_obs; i++) if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++; if ({obs_tgt[i], obs_dat[i]} !== {e.t, e.d}) begin errs++; $display("FAIL full_pkt%0d: got %h expected %h", i, {obs_tgt[i], obs_dat[i]}, {e.t, e.d}); end
    end
`ifdef BACKPRESSURE_EN
    checks++; if (drop0 !== 16'd0 || nf !== 0) begin errs++; $display("FAIL full_drop: got %0d drops %0d full launches expected 0/0", drop0, nf); end
    checks++; if (done_cyc !== 17) begin errs++; $display("FAIL full_done: got %0d expected 17", done_cyc); end
`else
    checks++; if (drop0 !== 16'd6 || nf !== 6) begin errs++; $display("FAIL full_drop: got %0d drops %0d full launches expected 6/6", drop0, nf); end
    checks++; if (done_cyc !== 11) begin errs++; $display("FAIL full_done: got %0d expected 11", done_cyc); end
`endif
    exp_q.delete();
  endtask

  initial begin
    for (int i = 0; i < 64; i++) begin full_pat[i] = 0; rst_pat[i] = 0; end
    test_reset();
    test_broadcast();
    test_midrun_reset();
    test_fixed_fallback();
    test_gap();
    test_zero_pkts();
    test_reserved_mode();
    test_port_full();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
